// File: rtl/sram_stage_scheduler.sv
// sram_stage_scheduler: top-level sequencer for the decompressor.
// Runs UART load -> milestone 2 -> milestone 1 -> display, hands the single
// SRAM port to the active stage only, and traps hung stages with a watchdog.
module sram_stage_scheduler #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd4000000,
  parameter int          GAP_CYCLES     = 2
) (
  input  logic        CLOCK_50_I,
  input  logic        Resetn,
  input  logic        go_i,
  input  logic        uart_finish,
  input  logic        m2_finish,
  input  logic        m1_finish,
  input  logic [17:0] uart_address,
  input  logic [17:0] m2_address,
  input  logic [17:0] m1_address,
  input  logic [17:0] vga_address,
  input  logic [15:0] uart_write_data,
  input  logic [15:0] m2_write_data,
  input  logic [15:0] m1_write_data,
  input  logic        uart_we_n,
  input  logic        m2_we_n,
  input  logic        m1_we_n,
  output logic        uart_start,
  output logic        m2_start,
  output logic        m1_start,
  output logic [17:0] SRAM_address,
  output logic [15:0] SRAM_write_data,
  output logic        SRAM_we_n,
  output logic [2:0]  stage_o,
  output logic        done_o,
  output logic        timeout_error
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_UART = 3'd1,
    S_GAP1 = 3'd2,
    S_M2   = 3'd3,
    S_GAP2 = 3'd4,
    S_M1   = 3'd5,
    S_DONE = 3'd6,
    S_ERR  = 3'd7
  } state_t;

  // Gap counter counts down from GAP_CYCLES-1 to 0, giving GAP_CYCLES idle cycles.
  localparam logic [2:0]  GAP_LOAD = 3'(GAP_CYCLES - 1);
  localparam logic [23:0] WD_LAST  = TIMEOUT_CYCLES - 24'd1;

  state_t      state;
  logic        go_q;
  logic        go_edge;
  logic        owner_finish;
  logic        wd_expired;
  logic [23:0] watchdog;
  logic [2:0]  gap_cnt;

  assign go_edge    = go_i & ~go_q;
  assign wd_expired = (watchdog == WD_LAST);
  assign stage_o    = state;

  // Finish is accepted only from the current owner and never in its start cycle,
  // so a stage always owns the bus for at least two cycles.
  always_comb begin
    owner_finish = 1'b0;
    case (state)
      S_UART:  owner_finish = uart_finish & ~uart_start;
      S_M2:    owner_finish = m2_finish & ~m2_start;
      S_M1:    owner_finish = m1_finish & ~m1_start;
      default: owner_finish = 1'b0;
    endcase
  end

  // Sequencer: stage stepping, start pulses, gap timing and watchdog.
  always_ff @(posedge CLOCK_50_I or negedge Resetn) begin
    if (!Resetn) begin
      state         <= S_IDLE;
      go_q          <= 1'b0;
      uart_start    <= 1'b0;
      m2_start      <= 1'b0;
      m1_start      <= 1'b0;
      done_o        <= 1'b0;
      timeout_error <= 1'b0;
      watchdog      <= 24'd0;
      gap_cnt       <= 3'd0;
    end else begin
      go_q       <= go_i;
      uart_start <= 1'b0;
      m2_start   <= 1'b0;
      m1_start   <= 1'b0;
      case (state)
        S_IDLE, S_DONE: begin
          if (go_edge) begin
            state      <= S_UART;
            uart_start <= 1'b1;
            watchdog   <= 24'd0;
            done_o     <= 1'b0;
          end
        end
        S_UART, S_M2, S_M1: begin
          // A finish in the same cycle as expiry still completes the stage.
          if (owner_finish) begin
            case (state)
              S_UART: begin
                state   <= S_GAP1;
                gap_cnt <= GAP_LOAD;
              end
              S_M2: begin
                state   <= S_GAP2;
                gap_cnt <= GAP_LOAD;
              end
              default: begin
                state  <= S_DONE;
                done_o <= 1'b1;
              end
            endcase
          end else if (wd_expired) begin
            state         <= S_ERR;
            timeout_error <= 1'b1;
          end else begin
            watchdog <= watchdog + 24'd1;
          end
        end
        S_GAP1: begin
          if (gap_cnt == 3'd0) begin
            state    <= S_M2;
            m2_start <= 1'b1;
            watchdog <= 24'd0;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        S_GAP2: begin
          if (gap_cnt == 3'd0) begin
            state    <= S_M1;
            m1_start <= 1'b1;
            watchdog <= 24'd0;
          end else begin
            gap_cnt <= gap_cnt - 3'd1;
          end
        end
        default: begin
          // ERR is terminal until reset; the bus stays idle.
          state <= S_ERR;
        end
      endcase
    end
  end

  // Bus mux: only the owning stage drives SRAM; display is read-only.
  always_comb begin
    SRAM_address    = 18'd0;
    SRAM_write_data = 16'd0;
    SRAM_we_n       = 1'b1;
    case (state)
      S_UART: begin
        SRAM_address    = uart_address;
        SRAM_write_data = uart_write_data;
        SRAM_we_n       = uart_we_n;
      end
      S_M2: begin
        SRAM_address    = m2_address;
        SRAM_write_data = m2_write_data;
        SRAM_we_n       = m2_we_n;
      end
      S_M1: begin
        SRAM_address    = m1_address;
        SRAM_write_data = m1_write_data;
        SRAM_we_n       = m1_we_n;
      end
      S_DONE: begin
        SRAM_address = vga_address;
      end
      default: begin
        SRAM_address    = 18'd0;
        SRAM_write_data = 16'd0;
        SRAM_we_n       = 1'b1;
      end
    endcase
  end

endmodule

// File: tb/tb_sram_stage_scheduler.sv
// Directed bench for sram_stage_scheduler: full run, bus isolation, stray
// finishes, watchdog timeout, DONE/restart and mid-run reset.
module tb_sram_stage_scheduler;

  logic        CLOCK_50_I = 1'b0;
  logic        Resetn, go_i;
  logic        uart_finish, m2_finish, m1_finish;
  logic [17:0] uart_address, m2_address, m1_address, vga_address;
  logic [15:0] uart_write_data, m2_write_data, m1_write_data;
  logic        uart_we_n, m2_we_n, m1_we_n;

  logic        uart_start, m2_start, m1_start;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;
  logic [2:0]  stage_o;
  logic        done_o, timeout_error;

  logic        t_uart_start, t_m2_start, t_m1_start;
  logic [17:0] t_SRAM_address;
  logic [15:0] t_SRAM_write_data;
  logic        t_SRAM_we_n;
  logic [2:0]  t_stage_o;
  logic        t_done_o, t_timeout_error;

  always #5 CLOCK_50_I = ~CLOCK_50_I;

  sram_stage_scheduler dut (
    .CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .go_i(go_i),
    .uart_finish(uart_finish), .m2_finish(m2_finish), .m1_finish(m1_finish),
    .uart_address(uart_address), .m2_address(m2_address), .m1_address(m1_address),
    .vga_address(vga_address),
    .uart_write_data(uart_write_data), .m2_write_data(m2_write_data), .m1_write_data(m1_write_data),
    .uart_we_n(uart_we_n), .m2_we_n(m2_we_n), .m1_we_n(m1_we_n),
    .uart_start(uart_start), .m2_start(m2_start), .m1_start(m1_start),
    .SRAM_address(SRAM_address), .SRAM_write_data(SRAM_write_data), .SRAM_we_n(SRAM_we_n),
    .stage_o(stage_o), .done_o(done_o), .timeout_error(timeout_error)
  );

  // Short-watchdog instance sharing all inputs; only checked in the timeout phase.
  sram_stage_scheduler #(.TIMEOUT_CYCLES(24'd16), .GAP_CYCLES(2)) dut_t (
    .CLOCK_50_I(CLOCK_50_I), .Resetn(Resetn), .go_i(go_i),
    .uart_finish(uart_finish), .m2_finish(m2_finish), .m1_finish(m1_finish),
    .uart_address(uart_address), .m2_address(m2_address), .m1_address(m1_address),
    .vga_address(vga_address),
    .uart_write_data(uart_write_data), .m2_write_data(m2_write_data), .m1_write_data(m1_write_data),
    .uart_we_n(uart_we_n), .m2_we_n(m2_we_n), .m1_we_n(m1_we_n),
    .uart_start(t_uart_start), .m2_start(t_m2_start), .m1_start(t_m1_start),
    .SRAM_address(t_SRAM_address), .SRAM_write_data(t_SRAM_write_data), .SRAM_we_n(t_SRAM_we_n),
    .stage_o(t_stage_o), .done_o(t_done_o), .timeout_error(t_timeout_error)
  );

  typedef struct {
    logic        uwe;
    logic [17:0] uad;
    logic [15:0] udt;
    logic        m2we;
    logic [17:0] m2ad;
    logic [15:0] m2dt;
    logic        m1we;
    logic [17:0] m1ad;
    logic [15:0] m1dt;
    logic [17:0] exp_ad;
    logic [15:0] exp_dt;
    logic        exp_we;
  } vec_t;

  vec_t vecs[4];
  int   total;
  int   bad;
  int   cyc;
  int   s;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50_I);
    #1;
    cyc++;
  endtask

  initial begin
    total = 0; bad = 0; cyc = 0;
    Resetn = 1'b0; go_i = 1'b0;
    uart_finish = 1'b0; m2_finish = 1'b0; m1_finish = 1'b0;
    uart_address = 18'h12345; m2_address = 18'd0; m1_address = 18'd0; vga_address = 18'd0;
    uart_write_data = 16'hCAFE; m2_write_data = 16'd0; m1_write_data = 16'd0;
    uart_we_n = 1'b0; m2_we_n = 1'b1; m1_we_n = 1'b1;

    vecs[0] = '{1'b0, 18'h3FFFF, 16'hFFFF, 1'b1, 18'd76800, 16'h1234, 1'b1, 18'h00155, 16'hAAAA,
                18'd76800, 16'h1234, 1'b1};
    vecs[1] = '{1'b0, 18'h3FFFF, 16'hFFFF, 1'b1, 18'd76800, 16'h1234, 1'b0, 18'h00155, 16'hAAAA,
                18'd76800, 16'h1234, 1'b1};
    vecs[2] = '{1'b0, 18'h3FFFF, 16'hFFFF, 1'b0, 18'h2ABCD, 16'hBEEF, 1'b0, 18'h00155, 16'hAAAA,
                18'h2ABCD, 16'hBEEF, 1'b0};
    vecs[3] = '{1'b0, 18'h00001, 16'h0001, 1'b1, 18'h00000, 16'h0000, 1'b0, 18'h3FFFF, 16'hFFFF,
                18'h00000, 16'h0000, 1'b1};

    // Reset state, with a non-owner trying to write.
    step(); step();
    chk("rst_stage", stage_o, 0);
    chk("rst_uart_start", uart_start, 0);
    chk("rst_m2_start", m2_start, 0);
    chk("rst_m1_start", m1_start, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", timeout_error, 0);
    chk("rst_we_n", SRAM_we_n, 1);
    chk("rst_addr", SRAM_address, 0);
    chk("rst_data", SRAM_write_data, 0);
    Resetn = 1'b1;
    step();
    chk("idle_hold", stage_o, 0);

    // Full run: UART stage.
    go_i = 1'b1;
    step();
    s = cyc;
    chk("uart_enter", stage_o, 1);
    chk("uart_start_pulse", uart_start, 1);
    chk("uart_bus_addr", SRAM_address, 18'h12345);
    chk("uart_bus_data", SRAM_write_data, 16'hCAFE);
    chk("uart_bus_we", SRAM_we_n, 0);
    uart_finish = 1'b1;
    step();
    uart_finish = 1'b0;
    chk("start_cycle_finish_ignored", stage_o, 1);
    chk("uart_start_one_cycle", uart_start, 0);
    m1_finish = 1'b1; m2_finish = 1'b1;
    step();
    m1_finish = 1'b0; m2_finish = 1'b0;
    chk("stray_finish_ignored", stage_o, 1);
    while (cyc < s + 10) step();
    uart_finish = 1'b1;
    step();
    uart_finish = 1'b0;
    chk("gap1_enter", stage_o, 2);
    chk("gap1_we_n", SRAM_we_n, 1);
    chk("gap1_addr", SRAM_address, 0);
    step();
    chk("gap1_second", stage_o, 2);
    chk("gap1_second_we_n", SRAM_we_n, 1);
    step();
    s = cyc;
    chk("m2_enter", stage_o, 3);
    chk("m2_start_pulse", m2_start, 1);

    // Bus isolation vectors in M2.
    for (int i = 0; i < 4; i++) begin
      uart_we_n = vecs[i].uwe; uart_address = vecs[i].uad; uart_write_data = vecs[i].udt;
      m2_we_n = vecs[i].m2we;  m2_address = vecs[i].m2ad;  m2_write_data = vecs[i].m2dt;
      m1_we_n = vecs[i].m1we;  m1_address = vecs[i].m1ad;  m1_write_data = vecs[i].m1dt;
      #1;
      $display("vec %0d: addr=%h data=%h we_n=%b", i, SRAM_address, SRAM_write_data, SRAM_we_n);
      chk($sformatf("vec%0d_addr", i), SRAM_address, vecs[i].exp_ad);
      chk($sformatf("vec%0d_data", i), SRAM_write_data, vecs[i].exp_dt);
      chk($sformatf("vec%0d_we_n", i), SRAM_we_n, vecs[i].exp_we);
      step();
      chk($sformatf("vec%0d_stage", i), stage_o, 3);
      chk($sformatf("vec%0d_m2_start", i), m2_start, 0);
    end
    go_i = 1'b0;
    step();
    go_i = 1'b1;
    step();
    chk("go_edge_in_m2_ignored", stage_o, 3);
    while (cyc < s + 30) step();
    m2_finish = 1'b1;
    step();
    m2_finish = 1'b0;
    chk("gap2_enter", stage_o, 4);
    step();
    chk("gap2_second", stage_o, 4);
    step();
    s = cyc;
    chk("m1_enter", stage_o, 5);
    chk("m1_start_pulse", m1_start, 1);
    m1_we_n = 1'b0; m1_address = 18'h00100; m1_write_data = 16'h5A5A; m2_we_n = 1'b0;
    #1;
    chk("m1_bus_addr", SRAM_address, 18'h00100);
    chk("m1_bus_data", SRAM_write_data, 16'h5A5A);
    chk("m1_bus_we", SRAM_we_n, 0);
    while (cyc < s + 60) step();
    m1_finish = 1'b1;
    step();
    m1_finish = 1'b0;
    chk("done_enter", stage_o, 6);
    chk("done_flag", done_o, 1);
    chk("done_m1_start", m1_start, 0);

    // DONE: VGA owns a read-only bus.
    vga_address = 18'd146944; uart_we_n = 1'b0;
    #1;
    chk("vga_addr", SRAM_address, 18'd146944);
    chk("vga_we_n", SRAM_we_n, 1);
    chk("vga_data", SRAM_write_data, 0);
    go_i = 1'b0;
    step();
    chk("done_hold", stage_o, 6);
    go_i = 1'b1;
    step();
    chk("restart_stage", stage_o, 1);
    chk("restart_uart_start", uart_start, 1);
    chk("restart_done_low", done_o, 0);

    // Quick second run, then reset asynchronously in the M1 start cycle.
    step();
    uart_finish = 1'b1;
    step();
    uart_finish = 1'b0;
    chk("run2_gap1", stage_o, 2);
    step(); step();
    chk("run2_m2", stage_o, 3);
    step();
    m2_finish = 1'b1;
    step();
    m2_finish = 1'b0;
    chk("run2_gap2", stage_o, 4);
    step(); step();
    chk("run2_m1", stage_o, 5);
    chk("run2_m1_start", m1_start, 1);
    chk("run2_m1_we", SRAM_we_n, 0);
    #2;
    Resetn = 1'b0;
    #1;
    chk("async_rst_we_n", SRAM_we_n, 1);
    chk("async_rst_stage", stage_o, 0);
    chk("async_rst_m1_start", m1_start, 0);
    chk("async_rst_done", done_o, 0);
    go_i = 1'b0;
    step();
    Resetn = 1'b1;
    step(); step(); step();
    chk("post_rst_idle", stage_o, 0);
    chk("post_rst_no_start", uart_start, 0);
    go_i = 1'b1;
    step();
    chk("post_rst_go", stage_o, 1);
    chk("post_rst_uart_start", uart_start, 1);

    // Watchdog timeout on the 16-cycle instance.
    Resetn = 1'b0; go_i = 1'b0; uart_we_n = 1'b0; uart_address = 18'h2AAAA;
    step();
    Resetn = 1'b1;
    step();
    go_i = 1'b1;
    step();
    s = cyc;
    chk("to_uart", t_stage_o, 1);
    chk("to_uart_start", t_uart_start, 1);
    repeat (15) step();
    chk("to_before_expiry", t_stage_o, 1);
    chk("to_err_clear", t_timeout_error, 0);
    step();
    chk("to_err_state", t_stage_o, 7);
    chk("to_err_flag", t_timeout_error, 1);
    chk("to_err_we_n", t_SRAM_we_n, 1);
    chk("to_err_addr", t_SRAM_address, 0);
    go_i = 1'b0;
    step();
    go_i = 1'b1;
    step();
    go_i = 1'b0;
    step();
    chk("to_go_ignored", t_stage_o, 7);
    chk("to_err_sticky", t_timeout_error, 1);
    Resetn = 1'b0;
    #1;
    chk("to_rst_stage", t_stage_o, 0);
    chk("to_rst_flag", t_timeout_error, 0);
    step();
    Resetn = 1'b1;
    step();

    // Finish arriving on the expiry cycle wins over the timeout.
    go_i = 1'b1;
    step();
    chk("fw_uart", t_stage_o, 1);
    repeat (15) step();
    uart_finish = 1'b1;
    step();
    uart_finish = 1'b0;
    chk("fw_gap1", t_stage_o, 2);
    chk("fw_no_err", t_timeout_error, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
